// File: rtl/pipe_sprite_scheduler.sv
// Shares one pipe sprite RAM among several on-screen pipes: picks the covering pipe per pixel,
// issues the texel read and re-times the returned palette index with its pixel.
module pipe_sprite_scheduler #(
    parameter int N_PIPES = 4,
    parameter int SPR_W   = 35,
    parameter int SPR_H   = 50,
    parameter int ADDR_W  = 19
) (
    input  logic                       CLK,
    input  logic                       Reset,
    input  logic                       frame_start,
    input  logic                       pix_en,
    input  logic [9:0]                 DrawX,
    input  logic [9:0]                 DrawY,
    input  logic                       cfg_we,
    input  logic [$clog2(N_PIPES)-1:0] cfg_idx,
    input  logic [9:0]                 cfg_x,
    input  logic [9:0]                 cfg_y,
    input  logic                       cfg_flip,
    input  logic                       cfg_active,
    output logic [ADDR_W-1:0]          READ_ADDR,
    input  logic [3:0]                 ram_data,
    output logic                       pix_valid,
    output logic                       pixel_hit,
    output logic [3:0]                 pixel_out
);

    localparam int IDX_W = $clog2(N_PIPES);

    logic [9:0] sh_x_q [N_PIPES];
    logic [9:0] sh_x_d [N_PIPES];
    logic [9:0] sh_y_q [N_PIPES];
    logic [9:0] sh_y_d [N_PIPES];
    logic       sh_flip_q [N_PIPES];
    logic       sh_flip_d [N_PIPES];
    logic       sh_act_q [N_PIPES];
    logic       sh_act_d [N_PIPES];
    logic [9:0] act_x_q [N_PIPES];
    logic [9:0] act_x_d [N_PIPES];
    logic [9:0] act_y_q [N_PIPES];
    logic [9:0] act_y_d [N_PIPES];
    logic       act_flip_q [N_PIPES];
    logic       act_flip_d [N_PIPES];
    logic       act_act_q [N_PIPES];
    logic       act_act_d [N_PIPES];

    logic [N_PIPES-1:0] hit_vec;
    logic               hit_any;
    logic [IDX_W-1:0]   win;
    logic [10:0]        lo_x, hi_x, lo_y, hi_y;
    logic [9:0]         col, dy, row;
    logic [ADDR_W-1:0]  addr;

    logic [ADDR_W-1:0]  read_addr_q, read_addr_d;
    logic               s1_valid_q, s1_valid_d;
    logic               s1_hit_q, s1_hit_d;
    logic               pix_valid_q, pix_valid_d;
    logic               pixel_hit_q, pixel_hit_d;
    logic [3:0]         pixel_out_q, pixel_out_d;

    // Shadow writes; the active copy is refreshed only at frame start, seeing same-cycle writes.
    always_comb begin
        for (int i = 0; i < N_PIPES; i++) begin
            sh_x_d[i]     = (cfg_we && (cfg_idx == IDX_W'(i))) ? cfg_x      : sh_x_q[i];
            sh_y_d[i]     = (cfg_we && (cfg_idx == IDX_W'(i))) ? cfg_y      : sh_y_q[i];
            sh_flip_d[i]  = (cfg_we && (cfg_idx == IDX_W'(i))) ? cfg_flip   : sh_flip_q[i];
            sh_act_d[i]   = (cfg_we && (cfg_idx == IDX_W'(i))) ? cfg_active : sh_act_q[i];
            act_x_d[i]    = frame_start ? sh_x_d[i]    : act_x_q[i];
            act_y_d[i]    = frame_start ? sh_y_d[i]    : act_y_q[i];
            act_flip_d[i] = frame_start ? sh_flip_d[i] : act_flip_q[i];
            act_act_d[i]  = frame_start ? sh_act_d[i]  : act_act_q[i];
        end
    end

    // Per-pipe coverage test; bounds in 11 bits so pipes near the right/bottom edge do not wrap.
    always_comb begin
        hit_vec = {N_PIPES{1'b0}};
        lo_x = 11'd0;
        hi_x = 11'd0;
        lo_y = 11'd0;
        hi_y = 11'd0;
        for (int i = 0; i < N_PIPES; i++) begin
            lo_x = {1'b0, act_x_q[i]};
            hi_x = lo_x + 11'(SPR_W);
            lo_y = {1'b0, act_y_q[i]};
            hi_y = lo_y + 11'(SPR_H);
            hit_vec[i] = act_act_q[i]
                       && ({1'b0, DrawX} >= lo_x) && ({1'b0, DrawX} < hi_x)
                       && ({1'b0, DrawY} >= lo_y) && ({1'b0, DrawY} < hi_y);
        end
    end

    // Lowest index wins outright, even if its texel later turns out transparent.
    always_comb begin
        win = {IDX_W{1'b0}};
        for (int i = N_PIPES - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                win = IDX_W'(i);
            end else begin
                win = win;
            end
        end
        hit_any = |hit_vec;
        col     = DrawX - act_x_q[win];
        dy      = DrawY - act_y_q[win];
        row     = act_flip_q[win] ? (10'(SPR_H - 1) - dy) : dy;
        addr    = ADDR_W'(row) * ADDR_W'(SPR_W) + ADDR_W'(col);
    end

    // Stage 1 issues the RAM address; stage 2 pairs the returned texel with its pixel.
    always_comb begin
        read_addr_d = pix_en ? (hit_any ? addr : {ADDR_W{1'b0}}) : read_addr_q;
        s1_valid_d  = pix_en;
        s1_hit_d    = pix_en & hit_any;
        pix_valid_d = s1_valid_q;
        pixel_hit_d = s1_valid_q & s1_hit_q & (ram_data != 4'd0);
        pixel_out_d = pixel_hit_d ? ram_data : 4'd0;
    end

    // Configuration registers.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            for (int i = 0; i < N_PIPES; i++) begin
                sh_x_q[i]     <= 10'd0;
                sh_y_q[i]     <= 10'd0;
                sh_flip_q[i]  <= 1'b0;
                sh_act_q[i]   <= 1'b0;
                act_x_q[i]    <= 10'd0;
                act_y_q[i]    <= 10'd0;
                act_flip_q[i] <= 1'b0;
                act_act_q[i]  <= 1'b0;
            end
        end else begin
            for (int i = 0; i < N_PIPES; i++) begin
                sh_x_q[i]     <= sh_x_d[i];
                sh_y_q[i]     <= sh_y_d[i];
                sh_flip_q[i]  <= sh_flip_d[i];
                sh_act_q[i]   <= sh_act_d[i];
                act_x_q[i]    <= act_x_d[i];
                act_y_q[i]    <= act_y_d[i];
                act_flip_q[i] <= act_flip_d[i];
                act_act_q[i]  <= act_act_d[i];
            end
        end
    end

    // Pixel pipeline registers; reset drops anything in flight.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            read_addr_q <= {ADDR_W{1'b0}};
            s1_valid_q  <= 1'b0;
            s1_hit_q    <= 1'b0;
            pix_valid_q <= 1'b0;
            pixel_hit_q <= 1'b0;
            pixel_out_q <= 4'd0;
        end else begin
            read_addr_q <= read_addr_d;
            s1_valid_q  <= s1_valid_d;
            s1_hit_q    <= s1_hit_d;
            pix_valid_q <= pix_valid_d;
            pixel_hit_q <= pixel_hit_d;
            pixel_out_q <= pixel_out_d;
        end
    end

    assign READ_ADDR = read_addr_q;
    assign pix_valid = pix_valid_q;
    assign pixel_hit = pixel_hit_q;
    assign pixel_out = pixel_out_q;

endmodule

// File: tb/tb_pipe_sprite_scheduler.sv
// Bench for pipe_sprite_scheduler: directed scenarios plus random traffic against a per-pixel
// reference model; every cycle's outputs are compared with the model's expectation.
module tb_pipe_sprite_scheduler;

    localparam int N    = 4;
    localparam int SW   = 35;
    localparam int SH   = 50;
    localparam int AW   = 19;
    localparam int MAXC = 4096;

    logic          CLK = 1'b0;
    logic          Reset;
    logic          frame_start = 1'b0;
    logic          pix_en = 1'b0;
    logic [9:0]    DrawX = 10'd0;
    logic [9:0]    DrawY = 10'd0;
    logic          cfg_we = 1'b0;
    logic [1:0]    cfg_idx = 2'd0;
    logic [9:0]    cfg_x = 10'd0;
    logic [9:0]    cfg_y = 10'd0;
    logic          cfg_flip = 1'b0;
    logic          cfg_active = 1'b0;
    logic [AW-1:0] READ_ADDR;
    logic [3:0]    ram_data = 4'd0;
    logic          pix_valid;
    logic          pixel_hit;
    logic [3:0]    pixel_out;

    pipe_sprite_scheduler #(.N_PIPES(N), .SPR_W(SW), .SPR_H(SH), .ADDR_W(AW)) dut (
        .CLK(CLK), .Reset(Reset), .frame_start(frame_start), .pix_en(pix_en),
        .DrawX(DrawX), .DrawY(DrawY), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_flip(cfg_flip), .cfg_active(cfg_active),
        .READ_ADDR(READ_ADDR), .ram_data(ram_data), .pix_valid(pix_valid),
        .pixel_hit(pixel_hit), .pixel_out(pixel_out)
    );

    always #5 CLK = ~CLK;

    // Sprite RAM: address registered in the DUT, data available by the following edge.
    logic [3:0] mem [SW*SH];
    always @(negedge CLK) ram_data = mem[READ_ADDR];

    int sh_x [N], sh_y [N], act_x [N], act_y [N];
    bit sh_f [N], sh_a [N], act_f [N], act_a [N];
    int exp_addr [MAXC];
    bit exp_v [MAXC];
    bit exp_h [MAXC];
    int exp_o [MAXC];
    int last_addr = 0;
    int cyc = 0;
    bit started = 0;
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Which pipe covers (x,y) and the texel address it wants, straight from the geometry rules.
    function automatic void model_px(input int x, input int y, output bit hit, output int addr);
        int r;
        hit = 0;
        addr = 0;
        for (int i = 0; i < N; i++) begin
            if (!hit && act_a[i] && x >= act_x[i] && x < act_x[i] + SW
                && y >= act_y[i] && y < act_y[i] + SH) begin
                hit = 1;
                r = act_f[i] ? (SH - 1 - (y - act_y[i])) : (y - act_y[i]);
                addr = r * SW + (x - act_x[i]);
            end
        end
    endfunction

    // Per-cycle comparison of all outputs with the model's expectation.
    always @(posedge CLK) begin
        #1;
        cyc = cyc + 1;
        if (started) begin
            if (Reset) begin
                chk("rst_read_addr", int'(READ_ADDR), 0);
                chk("rst_pix_valid", int'(pix_valid), 0);
                chk("rst_pixel_hit", int'(pixel_hit), 0);
                chk("rst_pixel_out", int'(pixel_out), 0);
            end else begin
                chk("read_addr", int'(READ_ADDR), exp_addr[cyc]);
                chk("pix_valid", int'(pix_valid), int'(exp_v[cyc]));
                chk("pixel_hit", int'(pixel_hit), int'(exp_h[cyc]));
                chk("pixel_out", int'(pixel_out), exp_o[cyc]);
            end
        end
    end

    task automatic step(input bit pe, input int x, input int y, input bit we, input int idx,
                        input int cx, input int cy, input bit cf, input bit ca, input bit fs);
        bit h;
        int a;
        int c;
        pix_en = pe;
        DrawX = 10'(x);
        DrawY = 10'(y);
        cfg_we = we;
        cfg_idx = 2'(idx);
        cfg_x = 10'(cx);
        cfg_y = 10'(cy);
        cfg_flip = cf;
        cfg_active = ca;
        frame_start = fs;
        c = cyc;
        model_px(x, y, h, a);
        if (pe) last_addr = h ? a : 0;
        exp_addr[c+1] = last_addr;
        exp_v[c+2] = pe;
        exp_h[c+2] = pe && h && (mem[a] != 4'd0);
        exp_o[c+2] = exp_h[c+2] ? int'(mem[a]) : 0;
        if (we) begin
            sh_x[idx] = cx; sh_y[idx] = cy; sh_f[idx] = cf; sh_a[idx] = ca;
        end
        if (fs) begin
            for (int i = 0; i < N; i++) begin
                act_x[i] = sh_x[i]; act_y[i] = sh_y[i]; act_f[i] = sh_f[i]; act_a[i] = sh_a[i];
            end
        end
        @(posedge CLK);
        #2;
    endtask

    task automatic px(input int x, input int y);
        step(1, x, y, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic cfg(input int idx, input int x, input int y, input bit f, input bit a, input bit fs);
        step(0, 0, 0, 1, idx, x, y, f, a, fs);
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        pix_en = 1'b1;
        DrawX = 10'd100;
        DrawY = 10'd200;
        cfg_we = 1'b0;
        frame_start = 1'b0;
        for (int i = 0; i < N; i++) begin
            sh_x[i] = 0; sh_y[i] = 0; sh_f[i] = 0; sh_a[i] = 0;
            act_x[i] = 0; act_y[i] = 0; act_f[i] = 0; act_a[i] = 0;
        end
        last_addr = 0;
        started = 1;
        repeat (3) begin
            @(posedge CLK);
            #2;
        end
        Reset = 1'b0;
        exp_v[cyc+1] = 0;
        exp_h[cyc+1] = 0;
        exp_o[cyc+1] = 0;
    endtask

    initial begin
        int x, y, k;
        bit pe, we, fs;
        Reset = 1'b1;
        for (int a = 0; a < SW*SH; a++)
            mem[a] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
        mem[0] = 4'd0;
        mem[1749] = 4'd9;
        mem[1715] = 4'd3;
        mem[360] = 4'd6;
        @(posedge CLK);
        #2;
        do_reset();
        idle();
        idle();

        // Unflipped pipe 0 at (100,200)
        cfg(0, 100, 200, 0, 1, 0);
        cfg(3, 0, 0, 0, 0, 1);
        px(100, 200);
        chk("p0_topleft_addr", int'(READ_ADDR), 0);
        px(134, 249);
        chk("p0_botright_addr", int'(READ_ADDR), 1749);
        idle();
        chk("p0_botright_valid", int'(pix_valid), 1);
        chk("p0_botright_out", int'(pixel_out), 9);
        idle();

        // Same pipe flipped, plus the one-off column edges
        cfg(0, 100, 200, 1, 1, 1);
        px(100, 200);
        chk("flip_topleft_addr", int'(READ_ADDR), 1715);
        px(100, 249);
        chk("flip_botleft_addr", int'(READ_ADDR), 0);
        chk("flip_topleft_out", int'(pixel_out), 3);
        px(135, 200);
        chk("right_edge_addr", int'(READ_ADDR), 0);
        px(99, 200);
        chk("left_edge_addr", int'(READ_ADDR), 0);
        chk("right_edge_hit", int'(pixel_hit), 0);
        idle();
        chk("left_edge_hit", int'(pixel_hit), 0);

        // Overlapping pipes 0 and 2; pipe 0 texel transparent
        cfg(0, 300, 50, 0, 1, 0);
        cfg(2, 300, 50, 1, 1, 0);
        cfg(1, 500, 100, 0, 1, 1);
        px(300, 50);
        chk("overlap_addr", int'(READ_ADDR), 0);
        idle();
        chk("overlap_hit", int'(pixel_hit), 0);
        chk("overlap_out", int'(pixel_out), 0);

        // Shadow write without frame start, then write-through at frame start
        cfg(1, 600, 300, 0, 1, 0);
        px(510, 110);
        chk("shadow_only_addr", int'(READ_ADDR), 360);
        idle();
        chk("shadow_only_out", int'(pixel_out), 6);
        cfg(1, 700, 400, 0, 1, 1);
        px(710, 410);
        chk("writethru_addr", int'(READ_ADDR), 360);
        px(510, 110);
        chk("old_pos_addr", int'(READ_ADDR), 0);
        idle();
        chk("old_pos_hit", int'(pixel_hit), 0);

        // Back-to-back span across pipe 0's left edge
        for (int i = 0; i < 40; i++) px(280 + i, 60);
        idle();
        idle();

        // Random traffic, including pipes near the screen limit and a reset mid-stream
        for (int n = 0; n < 1500; n++) begin
            if (n == 700) begin
                do_reset();
                idle();
            end
            pe = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 1) begin
                k = $urandom_range(0, N - 1);
                x = act_x[k] + $urandom_range(0, SW + 10) - 5;
                y = act_y[k] + $urandom_range(0, SH + 10) - 5;
            end else begin
                x = $urandom_range(0, 1023);
                y = $urandom_range(0, 1023);
            end
            if (x < 0) x = 0;
            if (x > 1023) x = 1023;
            if (y < 0) y = 0;
            if (y > 1023) y = 1023;
            we = ($urandom_range(0, 7) == 0);
            fs = ($urandom_range(0, 40) == 0);
            step(pe, x, y, we, $urandom_range(0, N - 1),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(980, 1023) : $urandom_range(0, 1023),
                 ($urandom_range(0, 1) == 1) ? $urandom_range(970, 1023) : $urandom_range(0, 1023),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 3) != 0), fs);
        end
        idle();
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
